// File: rtl/decode_pipe_if.sv
// decode_pipe_if: fetch-side, writeback-side and execute-side bundle of the decode stage
interface decode_pipe_if #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 3,
   parameter int CTRL_W = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [15:0]       instruction;
   logic [DATA_W-1:0] PC_in;
   logic [DATA_W-1:0] next_PC_in;
   logic [REG_AW-1:0] rs_sel;
   logic [REG_AW-1:0] rt_sel;
   logic [REG_AW-1:0] rd_sel;
   logic              rs_used;
   logic              rt_used;
   logic              is_load;
   logic              regwrt_in;
   logic [1:0]        imm_mode;
   logic              zext;
   logic [CTRL_W-1:0] ctrl_in;
   logic              wb_en;
   logic [REG_AW-1:0] wb_reg;
   logic [DATA_W-1:0] wb_data;
   logic              flush;
   logic              out_ready;
   logic              out_valid;
   logic [DATA_W-1:0] srca;
   logic [DATA_W-1:0] srcb;
   logic [DATA_W-1:0] imm;
   logic [REG_AW-1:0] rd_out;
   logic              regwrt_out;
   logic              is_load_out;
   logic [CTRL_W-1:0] ctrl_out;
   logic [DATA_W-1:0] PC_out;
   logic [DATA_W-1:0] next_PC_out;
   logic              err;

   modport master (
      output in_valid, instruction, PC_in, next_PC_in, rs_sel, rt_sel, rd_sel, rs_used, rt_used,
             is_load, regwrt_in, imm_mode, zext, ctrl_in, wb_en, wb_reg, wb_data, flush, out_ready,
      input  in_ready, out_valid, srca, srcb, imm, rd_out, regwrt_out, is_load_out, ctrl_out,
             PC_out, next_PC_out, err
   );

   modport slave (
      input  in_valid, instruction, PC_in, next_PC_in, rs_sel, rt_sel, rd_sel, rs_used, rt_used,
             is_load, regwrt_in, imm_mode, zext, ctrl_in, wb_en, wb_reg, wb_data, flush, out_ready,
      output in_ready, out_valid, srca, srcb, imm, rd_out, regwrt_out, is_load_out, ctrl_out,
             PC_out, next_PC_out, err
   );
endinterface

// File: rtl/decode_pipe.sv
// decode_pipe: register file, immediate generation and ID/EX stage with one-bubble load-use stall
// Optional macro REGFILE_BYPASS_EN: same-cycle writeback-to-read bypass; without it a read of the
// register being written takes one bubble instead.
module decode_pipe #(
   parameter int DATA_W = 16,
   parameter int NREG   = 8,
   parameter int REG_AW = 3,
   parameter int CTRL_W = 16
) (
   input logic         clk,
   input logic         rst,
   decode_pipe_if.slave bus
);
   typedef struct packed {
      logic [DATA_W-1:0] srca;
      logic [DATA_W-1:0] srcb;
      logic [DATA_W-1:0] imm;
      logic [REG_AW-1:0] rd;
      logic              regwrt;
      logic              load;
      logic [CTRL_W-1:0] ctrl;
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] npc;
   } idex_t;

   logic [DATA_W-1:0] rf_q [NREG];
   idex_t             idex_q, idex_d;
   logic              valid_q, valid_d;
   logic              err_q, err_d;
   logic              rs_ok, rt_ok, wb_ok;
   logic              byp_rs, byp_rt, wb_haz;
   logic [DATA_W-1:0] rs_val, rt_val, imm_ext;
   logic              haz, adv, accept;
   logic              unused_ok;

   assign rs_ok = int'(bus.rs_sel) < NREG;
   assign rt_ok = int'(bus.rt_sel) < NREG;
   assign wb_ok = int'(bus.wb_reg) < NREG;

`ifdef REGFILE_BYPASS_EN
   assign byp_rs = bus.wb_en & (bus.wb_reg == bus.rs_sel);
   assign byp_rt = bus.wb_en & (bus.wb_reg == bus.rt_sel);
   assign wb_haz = 1'b0;
`else
   assign byp_rs = 1'b0;
   assign byp_rt = 1'b0;
   assign wb_haz = bus.wb_en & ((bus.rs_used & (bus.rs_sel == bus.wb_reg)) |
                                (bus.rt_used & (bus.rt_sel == bus.wb_reg)));
`endif

   assign rs_val = !rs_ok ? '0 : byp_rs ? bus.wb_data : rf_q[bus.rs_sel];
   assign rt_val = !rt_ok ? '0 : byp_rt ? bus.wb_data : rf_q[bus.rt_sel];

   assign imm_ext = bus.imm_mode == 2'd0 ? {{(DATA_W-5){~bus.zext & bus.instruction[4]}}, bus.instruction[4:0]} :
                    bus.imm_mode == 2'd1 ? {{(DATA_W-8){~bus.zext & bus.instruction[7]}}, bus.instruction[7:0]} :
                    bus.imm_mode == 2'd2 ? {{(DATA_W-11){~bus.zext & bus.instruction[10]}}, bus.instruction[10:0]} :
                    '0;

   assign haz = (valid_q & idex_q.load & idex_q.regwrt &
                 ((bus.rs_used & (bus.rs_sel == idex_q.rd)) | (bus.rt_used & (bus.rt_sel == idex_q.rd)))) | wb_haz;
   assign adv          = ~valid_q | bus.out_ready;
   assign bus.in_ready = bus.flush | (adv & ~haz);
   assign accept       = bus.in_valid & bus.in_ready & ~bus.flush;

   // Next ID/EX contents: flush kills validity only, advance loads or bubbles, otherwise hold
   always_comb begin
      idex_d  = idex_q;
      valid_d = bus.flush ? 1'b0 : adv ? accept : valid_q;
      err_d   = err_q | (accept & ((bus.rs_used & ~rs_ok) | (bus.rt_used & ~rt_ok))) | (bus.wb_en & ~wb_ok);
      if (!bus.flush && adv && accept) begin
         idex_d.srca   = rs_val;
         idex_d.srcb   = rt_val;
         idex_d.imm    = imm_ext;
         idex_d.rd     = bus.rd_sel;
         idex_d.regwrt = bus.regwrt_in;
         idex_d.load   = bus.is_load;
         idex_d.ctrl   = bus.ctrl_in;
         idex_d.pc     = bus.PC_in;
         idex_d.npc    = bus.next_PC_in;
      end
   end

   // ID/EX stage and sticky error register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idex_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         idex_q  <= idex_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   // Register file writes; out-of-range writeback targets are dropped
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      end else if (bus.wb_en && wb_ok) begin
         rf_q[bus.wb_reg] <= bus.wb_data;
      end
   end

   assign bus.out_valid   = valid_q;
   assign bus.srca        = idex_q.srca;
   assign bus.srcb        = idex_q.srcb;
   assign bus.imm         = idex_q.imm;
   assign bus.rd_out      = idex_q.rd;
   assign bus.regwrt_out  = idex_q.regwrt;
   assign bus.is_load_out = idex_q.load;
   assign bus.ctrl_out    = idex_q.ctrl;
   assign bus.PC_out      = idex_q.pc;
   assign bus.next_PC_out = idex_q.npc;
   assign bus.err         = err_q;
   assign unused_ok       = ^bus.instruction[15:11];
endmodule

// File: doc/decode_pipe.md
Name: decode_pipe

Overview:
- Parametrised successor to the single-cycle decode stage, for the pipelined processor.
- Contains the register file (NREG x DATA_W) and immediate generation, and registers the result into an ID/EX output stage with valid/ready handshakes on both sides.
- Detects load-use hazards against the instruction held in ID/EX and inserts one bubble.
- Accepts synchronous flush from branch resolution.

Parameters:
DATA_W, 16, datapath/register width (>=16)
NREG, 8, number of architectural registers
REG_AW, 3, register-select width; NREG <= 2**REG_AW
CTRL_W, 16, width of opaque control bundle passed through to execute

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  fetch/decode holds a valid instruction
in_ready  out  1  stage accepts instruction this cycle
instruction  in  16  raw instruction; imm fields [4:0], [7:0], [10:0]
PC_in  in  DATA_W  PC of instruction
next_PC_in  in  DATA_W  PC+2
rs_sel, rt_sel, rd_sel  in  REG_AW each  source A, source B, destination selects
rs_used, rt_used  in  1 each  source actually read (hazard qualifier)
is_load  in  1  instruction is a memory load
regwrt_in  in  1  instruction writes rd
imm_mode  in  2  0: imm5, 1: imm8, 2: imm11, 3: zero
zext  in  1  1 = zero-extend imm, 0 = sign-extend
ctrl_in  in  CTRL_W  control bundle, passed through
wb_en  in  1  writeback enable
wb_reg  in  REG_AW  writeback register
wb_data  in  DATA_W  writeback data
flush  in  1  discard ID/EX contents and current input
out_ready  in  1  execute accepts ID/EX
out_valid  out  1  ID/EX holds a valid instruction
srca, srcb  out  DATA_W each  registered operand values
imm  out  DATA_W  registered extended immediate
rd_out  out  REG_AW  registered destination
regwrt_out, is_load_out  out  1 each  registered flags
ctrl_out  out  CTRL_W  registered control bundle
PC_out, next_PC_out  out  DATA_W each  registered PCs
err  out  1  sticky error flag

Behaviour:
- Reset, asynchronous: all registers to 0; out_valid=0, err=0, every ID/EX output 0.
- Register file:
  - Write on posedge when wb_en; no hardwired zero register.
  - Reads are combinational from rs_sel/rt_sel.
- Immediate:
  - imm5 = instruction[4:0], imm8 = [7:0], imm11 = [10:0], extended to DATA_W by zext.
  - Mode 3 yields 0. The 11-bit field is always extended by the zext value (no special case).
- Hazard (combinational):
  - haz = out_valid & is_load_out & regwrt_out & ((rs_used & rs_sel==rd_out) | (rt_used & rt_sel==rd_out)).
- Handshake:
  - adv = ~out_valid | out_ready.
  - in_ready = flush | (adv & ~haz).
  - Accept = in_valid & in_ready & ~flush.
- ID/EX update on posedge:
  - flush: out_valid<=0; data fields unchanged.
  - else if adv & accept: load all fields; out_valid<=1.
  - else if adv: out_valid<=0 (bubble).
  - else: hold all fields (stall).
- Latency: one cycle from accept to out_valid.
- Back-to-back throughput: one instruction per cycle with no hazard.
- Load-use: exactly one bubble.
  - Load leaves ID/EX, bubble enters, dependent instruction accepted the following cycle.
  - If out_ready is low, the stall persists with no extra bubbles.
- Flush takes priority over stall and hazard. wb writes still commit during flush.
- err sets on an accepted instruction with a used select >= NREG, or on wb_en with wb_reg >= NREG.
  - Out-of-range writes are dropped; out-of-range reads return 0.
  - err clears only on rst.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: write-before-read bypass.
  - A read whose select equals wb_reg while wb_en=1 returns wb_data in the same cycle.
  - The hazard term is as above.
- Undefined: reads return the stored value.
  - haz additionally asserts when wb_en & ((rs_used & rs_sel==wb_reg) | (rt_used & rt_sel==wb_reg)).
  - This forces one bubble, so the value is read the next cycle.

Test Plan:
- Reset, then wb_en reg3=0x1234. Next cycle accept rs_sel=3 -> after 1 cycle out_valid=1, srca=0x1234.
- instruction=0x001F, imm_mode=0, zext=0 -> imm=0xFFFF; with zext=1 -> imm=0x001F; imm_mode=2 with instruction=0x0400, zext=0 -> imm=0xFC00.
- Load rd=2 in ID/EX, next instruction rs_sel=2 rs_used=1 -> in_ready=0 one cycle, one out_valid=0 bubble, then accepted; with rs_used=0 -> no bubble.
- out_ready=0 for 3 cycles with a valid ID/EX -> all outputs held, in_ready=0, no instruction lost or duplicated.
- flush with ID/EX valid and in_valid=1 -> next cycle out_valid=0, input discarded; concurrent wb write to reg5=0xBEEF visible afterwards.
- Same-cycle wb_en reg4=0x00AA and read rs_sel=4 -> srca=0x00AA with macro defined; one bubble then 0x00AA without it.
